// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment display driver.
// Latches per-digit hex/attribute vectors on load into a shadow bank,
// promotes them to the active bank at each slot boundary, and scans one
// digit per slot with an all-off guard interval and hardware blink.
// Optional build macro SEG_SCAN_DIM_EN adds a 4-bit bright input that
// PWMs the anode within the drive window.
//
// state   | meaning
// --------+-----------------------------------------------
// GUARD_S | first GUARD clocks of a slot, anodes/segments off
// DRIVE_S | rest of the slot, current digit driven if visible
module seg_scan_driver #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int DIGITS   = 8,
   parameter int GUARD    = 4,
   parameter int BLINK_HZ = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   digit_data,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blink_mask,
`ifdef SEG_SCAN_DIM_EN
   input  logic [3:0]            bright,
`endif
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            seg,
   output logic                  frame_done
);

   localparam int SLOT       = CLK_HZ / SCAN_HZ;
   localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int CW         = $clog2(SLOT);
   localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {GUARD_S, DRIVE_S} state_t;
   localparam state_t ST_RST = (GUARD == 0) ? DRIVE_S : GUARD_S;

   state_t               state, state_nxt;
   logic [CW-1:0]        slot_cnt, cnt_nxt;
   logic [IW-1:0]        idx;
   logic [BW-1:0]        blink_cnt;
   logic                 blink_off;
   logic                 slot_wrap, idx_wrap;

   logic [4*DIGITS-1:0]  sh_data, act_data;
   logic [DIGITS-1:0]    sh_en, sh_dp, sh_blink;
   logic [DIGITS-1:0]    act_en, act_dp, act_blink;

   logic [3:0]           nibble;
   logic                 visible;
   logic                 pwm_on;
   logic [DIGITS-1:0]    an_onehot;
   logic [6:0]           pattern;

   assign slot_wrap = (slot_cnt == CW'(SLOT - 1));
   assign idx_wrap  = (idx == IW'(DIGITS - 1));
   assign cnt_nxt   = slot_wrap ? '0 : slot_cnt + 1'b1;

   // Slot counter, digit index and end-of-frame pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_cnt   <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         slot_cnt   <= cnt_nxt;
         frame_done <= slot_wrap & idx_wrap;
         if (slot_wrap) idx <= idx_wrap ? '0 : idx + 1'b1;
      end
   end

   // Free-running blink phase, independent of the scan
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Shadow capture on load; active bank promoted at slot boundary,
   // taking a coincident load directly so the new value shows this slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_data   <= '0;
         sh_en     <= '0;
         sh_dp     <= '0;
         sh_blink  <= '0;
         act_data  <= '0;
         act_en    <= '0;
         act_dp    <= '0;
         act_blink <= '0;
      end else begin
         if (load) begin
            sh_data  <= digit_data;
            sh_en    <= digit_en;
            sh_dp    <= dp;
            sh_blink <= blink_mask;
         end
         if (slot_wrap) begin
            act_data  <= load ? digit_data : sh_data;
            act_en    <= load ? digit_en   : sh_en;
            act_dp    <= load ? dp         : sh_dp;
            act_blink <= load ? blink_mask : sh_blink;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RST;
      else      state <= state_nxt;
   end

   // FSM next state: tracks whether the upcoming count is past the guard
   always_comb begin
      state_nxt = state;
      case (state)
         GUARD_S: if (cnt_nxt >= CW'(GUARD)) state_nxt = DRIVE_S;
         DRIVE_S: if (slot_wrap && (GUARD > 0)) state_nxt = GUARD_S;
         default: state_nxt = ST_RST;
      endcase
   end

   // Current digit lookup, visibility and hex decode
   always_comb begin
      nibble    = act_data[4*idx +: 4];
      visible   = act_en[idx] & ~(act_blink[idx] & blink_off);
      an_onehot = DIGITS'(1) << idx;
      case (nibble)
         4'h0: pattern = 7'h3F;
         4'h1: pattern = 7'h06;
         4'h2: pattern = 7'h5B;
         4'h3: pattern = 7'h4F;
         4'h4: pattern = 7'h66;
         4'h5: pattern = 7'h6D;
         4'h6: pattern = 7'h7D;
         4'h7: pattern = 7'h07;
         4'h8: pattern = 7'h7F;
         4'h9: pattern = 7'h6F;
         4'hA: pattern = 7'h77;
         4'hB: pattern = 7'h7C;
         4'hC: pattern = 7'h39;
         4'hD: pattern = 7'h5E;
         4'hE: pattern = 7'h79;
         default: pattern = 7'h71;
      endcase
   end

`ifdef SEG_SCAN_DIM_EN
   // PWM gate: anode on for the first 'bright' clocks of each 16-clock window
   always_comb begin
      pwm_on = (4'(slot_cnt - CW'(GUARD)) < bright);
   end
`else
   assign pwm_on = 1'b1;
`endif

   // Registered pin outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= '0;
         seg <= '0;
      end else if (state == DRIVE_S && visible) begin
         an  <= pwm_on ? an_onehot : '0;
         seg <= {act_dp[idx], pattern};
      end else begin
         an  <= '0;
         seg <= '0;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an expected-output scoreboard.
module tb_seg_scan_driver;

   localparam int DIGITS     = 4;
   localparam int SLOT       = 16;
   localparam int GUARD      = 2;
   localparam int BLINK_HALF = 32;
   localparam int FRAME      = SLOT * DIGITS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digit_data = '0;
   logic [3:0]  digit_en = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  blink_mask = '0;
`ifdef SEG_SCAN_DIM_EN
   logic [3:0]  bright = 4'd15;
`endif
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   seg_scan_driver #(
      .CLK_HZ(1600), .SCAN_HZ(100), .DIGITS(DIGITS), .GUARD(GUARD), .BLINK_HZ(25)
   ) dut (
      .clk(clk), .rst(rst), .load(load),
      .digit_data(digit_data), .digit_en(digit_en), .dp(dp), .blink_mask(blink_mask),
`ifdef SEG_SCAN_DIM_EN
      .bright(bright),
`endif
      .an(an), .seg(seg), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] e_an;
      logic [7:0] e_seg;
      logic       e_fd;
   } exp_t;

   exp_t sb[$];
   int   n = 0;
   int   compared = 0;
   int   mismatched = 0;

   // Reference display contents: cur_* before switch_slot, new_* from it on
   logic [15:0] cur_data = '0, new_data = '0;
   logic [3:0]  cur_en = '0, new_en = '0, cur_dp = '0, new_dp = '0;
   logic [3:0]  cur_bl = '0, new_bl = '0;
   int          switch_slot = 0;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Expected pins just after rising edge number e (edges counted from reset release)
   function automatic exp_t expect_at(input int e);
      exp_t        r;
      int          m, c, s, d;
      logic        boff, vis;
      logic [15:0] dd;
      logic [3:0]  en, dpv, bl;
      m    = e - 1;
      c    = m % SLOT;
      s    = m / SLOT;
      d    = s % DIGITS;
      boff = ((m / BLINK_HALF) % 2) == 1;
      if (s >= switch_slot) begin
         dd = new_data; en = new_en; dpv = new_dp; bl = new_bl;
      end else begin
         dd = cur_data; en = cur_en; dpv = cur_dp; bl = cur_bl;
      end
      vis     = en[d] & ~(bl[d] & boff);
      r.e_an  = '0;
      r.e_seg = '0;
      if (c >= GUARD && vis) begin
         r.e_an  = 4'(1 << d);
         r.e_seg = {dpv[d], hex7(dd[4*d +: 4])};
`ifdef SEG_SCAN_DIM_EN
         if (((c - GUARD) % 16) >= int'(bright)) r.e_an = '0;
`endif
      end
      r.e_fd = (e % FRAME) == 0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
      compared++;
      assert (obs === req)
      else begin
         mismatched++;
         $error("FAIL %s at edge %0d: observed %02h expected %02h", tag, n, obs, req);
      end
   endtask

   task automatic tick();
      exp_t x;
      sb.push_back(expect_at(n + 1));
      @(posedge clk);
      n++;
      #1;
      x = sb.pop_front();
      chk("an", {4'h0, an}, {4'h0, x.e_an});
      chk("seg", seg, x.e_seg);
      chk("frame_done", {7'h0, frame_done}, {7'h0, x.e_fd});
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   // Advance until the slot count after the last edge equals p
   task automatic to_phase(input int p);
      for (int i = 0; i < SLOT && (n % SLOT) != p; i++) tick();
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] en,
                          input logic [3:0] dpv, input logic [3:0] bl);
      cur_data = new_data; cur_en = new_en; cur_dp = new_dp; cur_bl = new_bl;
      new_data = d; new_en = en; new_dp = dpv; new_bl = bl;
      switch_slot = (n + 1 + SLOT - 1) / SLOT;
      digit_data = d; digit_en = en; dp = dpv; blink_mask = bl;
      load = 1'b1;
      tick();
      load = 1'b0;
      // Inputs are don't-care without load; scramble them
      digit_data = 16'($urandom);
      digit_en   = 4'($urandom);
      dp         = 4'($urandom);
      blink_mask = 4'($urandom);
   endtask

   initial begin
      #3;
      chk("reset_an", {4'h0, an}, 8'h00);
      chk("reset_seg", seg, 8'h00);
      chk("reset_frame_done", {7'h0, frame_done}, 8'h00);
      #19 rst = 1'b1;
      n = 0;

      // Nothing loaded: dark display, frame pulses every FRAME clocks
      run(200);

      // Load landing exactly on a slot boundary
      to_phase(SLOT - 1);
      do_load(16'h3210, 4'hF, 4'h2, 4'h0);
      run(160);

      // Mid-slot load with partial enables
      to_phase(7);
      do_load(16'hFEDC, 4'h5, 4'h0, 4'h0);
      run(160);

      // Blink on digit 0 only
      to_phase(SLOT - 1);
      do_load(16'h3210, 4'hF, 4'h0, 4'h1);
      run(256);

`ifdef SEG_SCAN_DIM_EN
      bright = 4'd4;
      run(128);
      bright = 4'd0;
      run(64);
      bright = 4'd15;
      run(64);
`endif

      // Remaining glyphs, with decimal points
      to_phase(4);
      do_load(16'hBA98, 4'hF, 4'hF, 4'h0);
      run(128);
      to_phase(10);
      do_load(16'h7654, 4'hF, 4'h5, 4'h0);
      run(128);

      // Asynchronous reset in the middle of a drive window
      to_phase(8);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_an", {4'h0, an}, 8'h00);
      chk("async_reset_seg", seg, 8'h00);
      chk("async_reset_frame_done", {7'h0, frame_done}, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      n = 0;
      cur_data = '0; new_data = '0; cur_en = '0; new_en = '0;
      cur_dp = '0; new_dp = '0; cur_bl = '0; new_bl = '0;
      switch_slot = 0;
      run(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
